// File: rtl/spi_pkg.sv
// Shared types for the generic SPI master: FSM state encoding, the
// CPOL/CPHA mode pair and a counter-width helper.
package spi_pkg;

  // Transaction phases: chip-select setup, bit transfer, chip-select hold.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } state_t;

  // SPI mode: cpol is the SCLK idle level, cpha selects sampling edge.
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Width of a counter that must hold 0..n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator. While enabled, a half-period counter runs 0..CLK_DIV-1
// and SCLK toggles on each wrap. The strobes are high in the clk cycle whose
// closing edge produces the SCLK edge, so the master can act on the same
// clk edge that moves the pin. When disabled SCLK is parked at CPOL.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter bit CPOL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic sclk,
  output logic lead_stb,
  output logic trail_stb
);

  localparam int            DW       = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          wrap;

  // An edge is leading when SCLK leaves its idle level, trailing otherwise.
  assign wrap      = enable && (div_cnt == DIV_LAST);
  assign lead_stb  = wrap && (sclk == CPOL);
  assign trail_stb = wrap && (sclk != CPOL);

  // Half-period counter and the registered SCLK pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      sclk    <= CPOL;
    end else if (!enable) begin
      div_cnt <= '0;
      sclk    <= CPOL;
    end else if (wrap) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised SPI master: all four CPOL/CPHA modes, F_SIZE-bit frames,
// F_NUM back-to-back frames per transaction with CS held low, N_CS selects.
//
// Handshake: start_i is a request taken only in IDLE (and not in the done_o
// cycle); tx_load_o is a one-cycle strobe, combinational from the current
// state, marking the cycle whose closing edge captures tx_data_i, so the
// front-end must hold valid data whenever a load may occur. rx_valid_o is a
// one-cycle pulse qualifying rx_data_o; there is no backpressure.
module spi_master_gen
  import spi_pkg::*;
#(
  parameter int CPOL    = 0,
  parameter int CPHA    = 0,
  parameter int F_SIZE  = 8,
  parameter int F_NUM   = 1,
  parameter int CLK_DIV = 4,
  parameter int N_CS    = 1,
  parameter int C_SIZE  = $clog2(F_SIZE),
  parameter int S_SIZE  = (N_CS > 1) ? $clog2(N_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [S_SIZE-1:0] cs_sel_i,
  input  logic [F_SIZE-1:0] tx_data_i,
  output logic              tx_load_o,
  output logic [F_SIZE-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o,
  output logic              done_o,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCLK,
  output logic [N_CS-1:0]   CS,
  output state_t            state_o
);

  localparam spi_mode_t         MODE     = '{cpol: (CPOL != 0), cpha: (CPHA != 0)};
  localparam int                FW       = cnt_width(F_NUM);
  localparam int                DW       = cnt_width(CLK_DIV);
  localparam logic [C_SIZE-1:0] BIT_LAST = C_SIZE'(F_SIZE - 1);
  localparam logic [FW-1:0]     FRM_LAST = FW'(F_NUM - 1);
  localparam logic [DW-1:0]     DIV_LAST = DW'(CLK_DIV - 1);

  state_t            state, state_nxt;
  logic [DW-1:0]     phase_cnt;
  logic [C_SIZE-1:0] bit_cnt;
  logic [FW-1:0]     frm_cnt;
  logic [F_SIZE-1:0] sreg;
  logic [F_SIZE-1:0] rx_q;
  logic [N_CS-1:0]   cs_q;
  logic              mosi_q;
  logic              rxv_q;
  logic              done_q;

  logic lead_stb, trail_stb;
  logic sample_stb, shift_stb;
  logic frame_end, last_frame;
  logic start_ok, next_frame, trail_end, tx_load;

  // Active-low one-hot decode; an out-of-range index selects nobody.
  function automatic logic [N_CS-1:0] cs_decode(input logic [S_SIZE-1:0] sel);
    logic [N_CS-1:0] m;
    m = '1;
    for (int i = 0; i < N_CS; i++) begin
      if (sel == S_SIZE'(i)) m[i] = 1'b0;
    end
    return m;
  endfunction

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (MODE.cpol)
  ) u_sclk (
    .clk       (clk),
    .rst       (rst),
    .enable    (state == XFER),
    .sclk      (SCLK),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb)
  );

  // CPHA swaps which SCLK edge samples MISO and which one moves MOSI.
  assign sample_stb = MODE.cpha ? trail_stb : lead_stb;
  assign shift_stb  = MODE.cpha ? lead_stb  : trail_stb;
  // Each bit is one lead/trail pair, so a frame ends on its F_SIZE-th trail.
  assign frame_end  = trail_stb && (bit_cnt == '0);
  assign last_frame = (frm_cnt == '0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic and the single-cycle control strobes.
  always_comb begin
    state_nxt  = state;
    start_ok   = 1'b0;
    next_frame = 1'b0;
    trail_end  = 1'b0;
    case (state)
      IDLE: begin
        // The done_o cycle is already IDLE but must not restart.
        if (start_i && !done_q) begin
          start_ok  = 1'b1;
          state_nxt = LEAD;
        end
      end
      LEAD: begin
        if (phase_cnt == DIV_LAST) state_nxt = XFER;
      end
      XFER: begin
        if (frame_end) begin
          if (last_frame) state_nxt  = TRAIL;
          else            next_frame = 1'b1;
        end
      end
      TRAIL: begin
        if (phase_cnt == DIV_LAST) begin
          trail_end = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    tx_load = start_ok || next_frame;
  end

  // Setup/hold timer for the LEAD and TRAIL phases.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_cnt <= '0;
    end else if (((state == LEAD) || (state == TRAIL)) && (phase_cnt != DIV_LAST)) begin
      phase_cnt <= phase_cnt + 1'b1;
    end else begin
      phase_cnt <= '0;
    end
  end

  // Bit counter (per frame) and frame counter (per transaction).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      frm_cnt <= '0;
    end else if (start_ok) begin
      bit_cnt <= BIT_LAST;
      frm_cnt <= FRM_LAST;
    end else if (trail_stb) begin
      if (bit_cnt == '0) begin
        bit_cnt <= BIT_LAST;
        if (!last_frame) frm_cnt <= frm_cnt - 1'b1;
      end else begin
        bit_cnt <= bit_cnt - 1'b1;
      end
    end
  end

  // Shift register and MOSI. With CPHA=0 the MSB is driven at load time;
  // with CPHA=1 it is driven by the first leading edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg   <= '0;
      mosi_q <= 1'b0;
    end else if (tx_load) begin
      sreg <= tx_data_i;
      if (!MODE.cpha) mosi_q <= tx_data_i[F_SIZE-1];
    end else begin
      if (sample_stb) sreg <= {sreg[F_SIZE-2:0], MISO};
      // The final trail of the last frame has no further bit to present.
      if (shift_stb && !frame_end) mosi_q <= sreg[F_SIZE-1];
    end
  end

  // Received-frame register; with CPHA=1 the last bit arrives on the
  // frame-end edge itself, so it is merged in directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_q  <= '0;
      rxv_q <= 1'b0;
    end else begin
      rxv_q <= 1'b0;
      if (frame_end) begin
        rx_q  <= MODE.cpha ? {sreg[F_SIZE-2:0], MISO} : sreg;
        rxv_q <= 1'b1;
      end
    end
  end

  // Chip selects (latched at start) and the end-of-transaction pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_q   <= '1;
      done_q <= 1'b0;
    end else begin
      done_q <= trail_end;
      if (start_ok)       cs_q <= cs_decode(cs_sel_i);
      else if (trail_end) cs_q <= '1;
    end
  end

  assign tx_load_o  = tx_load;
  assign rx_data_o  = rx_q;
  assign rx_valid_o = rxv_q;
  assign busy_o     = (state != IDLE);
  assign done_o     = done_q;
  assign MOSI       = mosi_q;
  assign CS         = cs_q;
  assign state_o    = state;

endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: four instances covering mode 0 with four
// selects, mode 3 against a slave model, a three-frame burst, and the
// minimum divider/frame size in mode 1.
module tb_spi_master_gen;
  import spi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- instance A: mode 0, 4 selects, loopback ----------------
  logic       a_start = 1'b0;
  logic [1:0] a_sel   = '0;
  logic [7:0] a_tx    = '0;
  logic       a_load, a_rxv, a_busy, a_done, a_mosi, a_sclk;
  logic [7:0] a_rx;
  logic [3:0] a_cs;
  state_t     a_state;

  spi_master_gen #(.CPOL(0), .CPHA(0), .F_SIZE(8), .F_NUM(1), .CLK_DIV(2), .N_CS(4)) u_a (
    .clk(clk), .rst(rst), .start_i(a_start), .cs_sel_i(a_sel), .tx_data_i(a_tx),
    .tx_load_o(a_load), .rx_data_o(a_rx), .rx_valid_o(a_rxv), .busy_o(a_busy),
    .done_o(a_done), .MISO(a_mosi), .MOSI(a_mosi), .SCLK(a_sclk), .CS(a_cs),
    .state_o(a_state)
  );

  // ---------------- instance B: mode 3, slave model ----------------
  logic       b_start = 1'b0;
  logic [7:0] b_tx    = '0;
  logic       b_miso  = 1'b0;
  logic       b_load, b_rxv, b_busy, b_done, b_mosi, b_sclk;
  logic [7:0] b_rx;
  logic [0:0] b_cs;
  state_t     b_state;

  spi_master_gen #(.CPOL(1), .CPHA(1), .F_SIZE(8), .F_NUM(1), .CLK_DIV(2), .N_CS(1)) u_b (
    .clk(clk), .rst(rst), .start_i(b_start), .cs_sel_i(1'b0), .tx_data_i(b_tx),
    .tx_load_o(b_load), .rx_data_o(b_rx), .rx_valid_o(b_rxv), .busy_o(b_busy),
    .done_o(b_done), .MISO(b_miso), .MOSI(b_mosi), .SCLK(b_sclk), .CS(b_cs),
    .state_o(b_state)
  );

  // Mode 3 slave: drive on falling (leading), capture on rising (trailing).
  logic [7:0] b_slv_tx = 8'hC3;
  logic [7:0] b_slv_rx = '0;
  logic [2:0] b_bit    = 3'd7;
  always @(negedge b_sclk) if (b_cs[0] === 1'b0) b_miso = b_slv_tx[b_bit];
  always @(posedge b_sclk) if (b_cs[0] === 1'b0) begin
    b_slv_rx = {b_slv_rx[6:0], b_mosi};
    b_bit    = b_bit - 3'd1;
  end

  // ---------------- instance C: mode 0, three-frame burst, loopback ----------------
  logic       c_start = 1'b0;
  logic [7:0] c_tx    = '0;
  logic       c_load, c_rxv, c_busy, c_done, c_mosi, c_sclk;
  logic [7:0] c_rx;
  logic [0:0] c_cs;
  state_t     c_state;

  spi_master_gen #(.CPOL(0), .CPHA(0), .F_SIZE(8), .F_NUM(3), .CLK_DIV(2), .N_CS(1)) u_c (
    .clk(clk), .rst(rst), .start_i(c_start), .cs_sel_i(1'b0), .tx_data_i(c_tx),
    .tx_load_o(c_load), .rx_data_o(c_rx), .rx_valid_o(c_rxv), .busy_o(c_busy),
    .done_o(c_done), .MISO(c_mosi), .MOSI(c_mosi), .SCLK(c_sclk), .CS(c_cs),
    .state_o(c_state)
  );

  // ---------------- instance D: mode 1, F_SIZE=2, CLK_DIV=1 ----------------
  logic       d_start = 1'b0;
  logic [1:0] d_tx    = '0;
  logic       d_miso  = 1'b0;
  logic       d_load, d_rxv, d_busy, d_done, d_mosi, d_sclk;
  logic [1:0] d_rx;
  logic [0:0] d_cs;
  state_t     d_state;

  spi_master_gen #(.CPOL(0), .CPHA(1), .F_SIZE(2), .F_NUM(1), .CLK_DIV(1), .N_CS(1)) u_d (
    .clk(clk), .rst(rst), .start_i(d_start), .cs_sel_i(1'b0), .tx_data_i(d_tx),
    .tx_load_o(d_load), .rx_data_o(d_rx), .rx_valid_o(d_rxv), .busy_o(d_busy),
    .done_o(d_done), .MISO(d_miso), .MOSI(d_mosi), .SCLK(d_sclk), .CS(d_cs),
    .state_o(d_state)
  );

  // Mode 1 slave: drive on rising (leading), capture on falling (trailing).
  logic [1:0] d_slv_tx = 2'b01;
  logic [1:0] d_slv_rx = '0;
  logic [0:0] d_bit    = 1'b1;
  always @(posedge d_sclk) if (d_cs[0] === 1'b0) d_miso = d_slv_tx[d_bit];
  always @(negedge d_sclk) if (d_cs[0] === 1'b0) begin
    d_slv_rx = {d_slv_rx[0], d_mosi};
    d_bit    = d_bit - 1'b1;
  end

  // ---------------- scoreboards ----------------
  logic [7:0] a_exp_q[$];
  logic [7:0] b_exp_q[$];
  logic [7:0] c_exp_q[$];
  logic [1:0] d_exp_q[$];
  int a_rxv_cnt = 0, b_rxv_cnt = 0, c_rxv_cnt = 0, d_rxv_cnt = 0;

  always @(negedge clk) if (a_rxv === 1'b1) begin
    a_rxv_cnt++;
    check_eq("a_rx_pending", 32'(a_exp_q.size() > 0), 1);
    if (a_exp_q.size() > 0) check_eq("a_rx", a_rx, a_exp_q.pop_front());
  end
  always @(negedge clk) if (b_rxv === 1'b1) begin
    b_rxv_cnt++;
    check_eq("b_rx_pending", 32'(b_exp_q.size() > 0), 1);
    if (b_exp_q.size() > 0) check_eq("b_rx", b_rx, b_exp_q.pop_front());
  end
  always @(negedge clk) if (c_rxv === 1'b1) begin
    c_rxv_cnt++;
    check_eq("c_rx_pending", 32'(c_exp_q.size() > 0), 1);
    if (c_exp_q.size() > 0) check_eq("c_rx", c_rx, c_exp_q.pop_front());
  end
  always @(negedge clk) if (d_rxv === 1'b1) begin
    d_rxv_cnt++;
    check_eq("d_rx_pending", 32'(d_exp_q.size() > 0), 1);
    if (d_exp_q.size() > 0) check_eq("d_rx", d_rx, d_exp_q.pop_front());
  end

  // ---------------- instance A driver ----------------
  int         r_done_at, r_cs_low, r_busy, r_rises, r_dones, r_loads, r_rxv;
  logic [3:0] r_cs_and;

  // Call at #1 after a posedge; that cycle is k. extra_start re-asserts
  // start_i in cycle k+extra_start (negative: never).
  task automatic a_run(input logic [1:0] sel, input logic [7:0] data, input int extra_start);
    logic prev_sclk;
    int   cyc;
    int   rxv0;
    r_done_at = 0; r_cs_low = 0; r_busy = 0; r_rises = 0; r_dones = 0; r_loads = 0;
    r_cs_and  = 4'hf;
    rxv0      = a_rxv_cnt;
    prev_sclk = a_sclk;
    a_sel = sel; a_tx = data; a_start = 1'b1;
    a_exp_q.push_back(data);
    @(negedge clk);
    check_eq("a_tx_load_at_start", a_load, 1);
    cyc = 0;
    while (cyc < 300 && (r_done_at == 0 || cyc < r_done_at + 6)) begin
      @(posedge clk); #1;
      cyc++;
      a_start = (cyc == extra_start);
      a_tx    = 8'($urandom);
      a_sel   = 2'($urandom);
      @(negedge clk);
      if (a_cs != 4'hf) r_cs_low++;
      r_cs_and &= a_cs;
      if (a_busy) r_busy++;
      if (a_load) r_loads++;
      if (a_sclk && !prev_sclk) r_rises++;
      prev_sclk = a_sclk;
      if (a_done) begin
        r_dones++;
        if (r_done_at == 0) r_done_at = cyc;
      end
    end
    @(posedge clk); #1;
    a_start = 1'b0;
    r_rxv   = a_rxv_cnt - rxv0;
  endtask

  task automatic a_expect(input string t, input logic [3:0] cs_exp);
    check_eq({t, "_done_at"}, r_done_at, 37);
    check_eq({t, "_cs_low"},  r_cs_low, 36);
    check_eq({t, "_busy"},    r_busy, 36);
    check_eq({t, "_rises"},   r_rises, 8);
    check_eq({t, "_dones"},   r_dones, 1);
    check_eq({t, "_loads"},   r_loads, 0);
    check_eq({t, "_cs_seen"}, r_cs_and, cs_exp);
    check_eq({t, "_rxv_cnt"}, r_rxv, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] c_list [3];
    logic       prev_sclk, prev_mosi;
    int         cyc, done_at, cs_low, toggles, last_tog, gap_viol, loads, viol, rxv0;
    int         rise0, rise1;
    logic [1:0] rsel;
    logic [7:0] rdat;

    c_list[0] = 8'h11; c_list[1] = 8'h22; c_list[2] = 8'h33;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_a_cs",    a_cs, 4'hf);
    check_eq("rst_a_sclk",  a_sclk, 0);
    check_eq("rst_a_mosi",  a_mosi, 0);
    check_eq("rst_a_rx",    a_rx, 0);
    check_eq("rst_a_flags", {a_rxv, a_load, a_busy, a_done}, 4'b0000);
    check_eq("rst_a_state", a_state, IDLE);
    check_eq("rst_b_sclk",  b_sclk, 1);
    check_eq("rst_b_cs",    b_cs, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Mode 0 loopback, select 0.
    a_run(2'd0, 8'hA5, -1);
    a_expect("a_basic", 4'b1110);

    // Select 2 with a start_i re-asserted mid-transfer.
    a_run(2'd2, 8'h96, 12);
    a_expect("a_restart_mid", 4'b1011);

    // start_i in the done_o cycle is ignored.
    a_run(2'd1, 8'h4D, 37);
    a_expect("a_restart_done", 4'b1101);

    // Random selects and data.
    for (int i = 0; i < 3; i++) begin
      rsel = 2'($urandom_range(0, 3));
      rdat = 8'($urandom_range(0, 255));
      a_run(rsel, rdat, -1);
      a_expect("a_rand", ~(4'b0001 << rsel));
    end

    // Asynchronous reset in the middle of the fifth bit.
    a_sel = 2'd0; a_tx = 8'hFF; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    rxv0 = a_rxv_cnt;
    repeat (20) @(posedge clk);
    #1;
    check_eq("mid_a_sclk_high", a_sclk, 1);
    check_eq("mid_a_mosi_high", a_mosi, 1);
    rst = 1'b0;
    #1;
    check_eq("arst_a_cs",    a_cs, 4'hf);
    check_eq("arst_a_sclk",  a_sclk, 0);
    check_eq("arst_a_mosi",  a_mosi, 0);
    check_eq("arst_a_busy",  a_busy, 0);
    check_eq("arst_a_state", a_state, IDLE);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("arst_no_rxv", a_rxv_cnt - rxv0, 0);
    check_eq("arst_a_rx",   a_rx, 0);
    a_run(2'd0, 8'h5A, -1);
    a_expect("a_after_rst", 4'b1110);

    // Mode 3 against the slave model.
    b_slv_rx = '0; b_bit = 3'd7;
    rxv0 = b_rxv_cnt;
    b_tx = 8'h3C; b_start = 1'b1;
    b_exp_q.push_back(8'hC3);
    @(negedge clk);
    check_eq("b_tx_load_at_start", b_load, 1);
    prev_sclk = b_sclk; prev_mosi = b_mosi;
    @(posedge clk); #1;
    b_start = 1'b0;
    cyc = 0; done_at = 0; viol = 0;
    while (cyc < 200 && done_at == 0) begin
      cyc++;
      @(negedge clk);
      if (!b_cs[0] && (b_mosi != prev_mosi) && !(prev_sclk && !b_sclk)) viol++;
      prev_sclk = b_sclk; prev_mosi = b_mosi;
      if (b_done) done_at = cyc;
      @(posedge clk); #1;
    end
    check_eq("b_done_at",      done_at, 37);
    check_eq("b_slave_rx",     b_slv_rx, 8'h3C);
    check_eq("b_mosi_on_fall", viol, 0);
    check_eq("b_sclk_idle",    b_sclk, 1);
    check_eq("b_rxv_cnt",      b_rxv_cnt - rxv0, 1);

    // Three-frame burst, new data supplied on each tx_load_o.
    rxv0 = c_rxv_cnt;
    c_tx = c_list[0]; c_start = 1'b1;
    cyc = 0; done_at = 0; cs_low = 0; toggles = 0; last_tog = -1; gap_viol = 0; loads = 0;
    prev_sclk = c_sclk;
    while (cyc < 400 && done_at == 0) begin
      @(negedge clk);
      if (c_load) begin
        c_exp_q.push_back(c_tx);
        loads++;
      end
      if (cyc > 0) begin
        if (!c_cs[0]) cs_low++;
        if (c_sclk != prev_sclk) begin
          toggles++;
          if (last_tog >= 0 && (cyc - last_tog) != 2) gap_viol++;
          last_tog = cyc;
        end
        prev_sclk = c_sclk;
        if (c_done) done_at = cyc;
      end
      @(posedge clk); #1;
      cyc++;
      c_start = 1'b0;
      c_tx = (loads < 3) ? c_list[loads] : 8'($urandom);
    end
    check_eq("c_loads",    loads, 3);
    check_eq("c_done_at",  done_at, 101);
    check_eq("c_cs_low",   cs_low, 100);
    check_eq("c_toggles",  toggles, 48);
    check_eq("c_sclk_gap", gap_viol, 0);
    check_eq("c_rxv_cnt",  c_rxv_cnt - rxv0, 3);

    // Mode 1, two-bit frame, SCLK at clk/2.
    d_slv_rx = '0; d_bit = 1'b1;
    rxv0 = d_rxv_cnt;
    d_tx = 2'b10; d_start = 1'b1;
    d_exp_q.push_back(2'b01);
    prev_sclk = d_sclk;
    @(posedge clk); #1;
    d_start = 1'b0;
    cyc = 0; done_at = 0; rise0 = -1; rise1 = -1;
    while (cyc < 100 && done_at == 0) begin
      cyc++;
      @(negedge clk);
      if (d_sclk && !prev_sclk) begin
        if (rise0 < 0) rise0 = cyc;
        else if (rise1 < 0) rise1 = cyc;
      end
      prev_sclk = d_sclk;
      if (d_done) done_at = cyc;
      @(posedge clk); #1;
    end
    check_eq("d_done_at",     done_at, 7);
    check_eq("d_sclk_period", rise1 - rise0, 2);
    check_eq("d_slave_rx",    d_slv_rx, 2'b10);
    check_eq("d_rxv_cnt",     d_rxv_cnt - rxv0, 1);

    repeat (3) @(posedge clk);
    check_eq("queues_drained",
             a_exp_q.size() + b_exp_q.size() + c_exp_q.size() + d_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
- Parametrised, single-clock-domain SPI master; successor to the fixed-mode master.
- Supports all four CPOL/CPHA modes, any frame size, multi-frame bursts with CS held low, selectable slave select, and an integer SCLK divider.
- SCLK is a registered output generated from clk-domain edge strobes and is never used as a clock internally.
- Sits between a register/stream front-end and the external SPI pins.

Parameters:
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
- F_SIZE, 8, bits per frame (>=2).
- F_NUM, 1, frames per transaction (>=1).
- CLK_DIV, 4, clk cycles per SCLK half-period (>=1).
- N_CS, 1, number of slave-select lines.
- C_SIZE, $clog2(F_SIZE), bit counter width.
- S_SIZE, $clog2(N_CS) (min 1), cs_sel_i width.

Ports:
- clk, in, 1, system clock; all logic on posedge.
- rst, in, 1, asynchronous active-low reset (asserted when 0).
- start_i, in, 1, transaction request; sampled only in IDLE.
- cs_sel_i, in, S_SIZE, slave index; latched with start_i. Out-of-range values select no slave, but the transfer still runs.
- tx_data_i, in, F_SIZE, frame to send; MSB is sent first; sampled in every cycle where tx_load_o=1.
- tx_load_o, out, 1, one-cycle strobe marking the cycle tx_data_i is captured.
- rx_data_o, out, F_SIZE, last complete received frame; holds until the next frame completes.
- rx_valid_o, out, 1, one-cycle pulse when rx_data_o updates.
- busy_o, out, 1, high from the cycle after start_i is accepted until done_o.
- done_o, out, 1, one-cycle pulse at the end of the transaction.
- MISO, in, 1, serial input.
- MOSI, out, 1, serial output.
- SCLK, out, 1, serial clock.
- CS, out, N_CS, active-low slave selects.

Behaviour:
- Reset values: CS all 1; SCLK=CPOL; MOSI=0; rx_data_o=0; rx_valid_o, tx_load_o, busy_o and done_o all 0; state=IDLE; all counters 0. Reset mid-transfer returns every output to these values immediately (asynchronous). No partial frame is reported.
- FSM states: IDLE, LEAD, XFER, TRAIL.
- IDLE, start_i=1 at edge k:
  - tx_load_o=1 in cycle k, and tx_data_i is captured into the shift register.
  - cs_sel_i is latched and the frame counter is set to F_NUM-1.
  - Next state is LEAD.
  - CS[sel] goes low from k+1.
  - If CPHA=0, MOSI=MSB from k+1.
- start_i is ignored in every state except IDLE.
- LEAD: wait CLK_DIV cycles (setup), then go to XFER.
- XFER:
  - A half-period counter counts 0..CLK_DIV-1. At each wrap, SCLK toggles. The first toggle is the leading edge, then edges alternate.
  - Each frame has 2*F_SIZE edges.
  - Sample edge: the shift register takes MISO into the LSB.
  - Shift edge: MOSI is set to the next bit.
  - For CPHA=1, the first leading edge drives the MSB.
  - The bit counter runs from F_SIZE-1 down to 0.
- Frame end (final edge of a frame):
  - rx_data_o is updated and rx_valid_o pulses in the following cycle.
  - If frames remain: tx_load_o pulses in the same cycle as the frame-end edge, and the next frame starts without a gap. CS stays low and SCLK timing continues uninterrupted. For CPHA=0, MOSI presents the new MSB on that same edge.
  - If no frames remain: go to TRAIL, and SCLK is back at CPOL.
- TRAIL:
  - Wait CLK_DIV cycles.
  - Then deassert CS and pulse done_o in the same cycle, drop busy_o, and return to IDLE.
- Transaction latency from start edge k:
  - CS low for D + 2*F_SIZE*F_NUM*D + D cycles, where D=CLK_DIV.
  - done_o is high in cycle k+1+2D+2*F_SIZE*F_NUM*D.
- Boundary conditions:
  - CLK_DIV=1 gives SCLK = clk/2.
  - F_NUM=1 gives a single frame.
  - A start_i in the same cycle as done_o is ignored; the earliest restart is the next cycle.
  - The bit counter and frame counter wrap only at frame and transaction boundaries.

Decomposition:
- Package spi_pkg holds the state enum (IDLE, LEAD, XFER, TRAIL) and the spi_mode_t struct {cpol, cpha}.
- Sub-module spi_sclk_gen:
  - Inputs: enable, CLK_DIV, CPOL.
  - Outputs: SCLK plus lead_stb and trail_stb edge strobes, each one cycle wide.
  - Async active-low reset.
- The shift register, bit counter and frame counter live in spi_master_gen.

Test Plan:
- Mode 0, F_SIZE=8, CLK_DIV=2, MISO looped to MOSI, tx 0xA5:
  - rx_data_o=0xA5 with one rx_valid_o pulse.
  - 8 SCLK rising edges.
  - CS low for exactly 36 cycles; done_o at k+37.
- Mode 3 (CPOL=1, CPHA=1), tx 0x3C, slave model returns 0xC3:
  - SCLK idles high.
  - MOSI changes on falling edges; MISO is sampled on rising edges.
  - rx_data_o=0xC3.
- F_NUM=3, tx 0x11/0x22/0x33 supplied on each tx_load_o, loopback:
  - 3 tx_load_o and 3 rx_valid_o pulses.
  - rx values 0x11, 0x22, 0x33.
  - CS continuously low, with no SCLK gap between frames.
- N_CS=4, cs_sel_i=2, start_i re-asserted mid-transfer:
  - Only CS[2] goes low.
  - The second start is ignored; a single done_o pulse.
- rst driven to 0 at bit 4 of a frame:
  - CS=all 1, SCLK=CPOL, MOSI=0, busy_o=0 immediately.
  - No rx_valid_o pulse.
  - After release, a new 0x5A transfer completes correctly.
- CLK_DIV=1, F_SIZE=2, mode 1, tx 2'b10:
  - SCLK period is 2 clk cycles; rx matches the slave's 2'b01.
